// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the cipher-block to UART byte scheduler.
// Holds the scheduler state encoding and the default block size.
package uart_sched_pkg;

   localparam int DEFAULT_BLOCK_BYTES = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SYNC = 3'd2,
      SEND = 3'd3,
      WAIT = 3'd4,
      GAP  = 3'd5,
      FIN  = 3'd6
   } sched_state_t;

   // A block of one byte still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_block_scheduler_arbiter.sv
// Two-way round-robin priority decision; the last-grant state is held by the caller.
// Purely combinational.
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_req,
   output logic winner
);

   assign any_req = req0 | req1;
   // On a tie the requester served less recently wins.
   assign winner  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/uart_block_scheduler.sv
// Round-robin scheduler that takes whole cipher blocks from two requesters and
// feeds them byte by byte to a UART transmitter through its DV/Done handshake.
module uart_block_scheduler
   import uart_sched_pkg::*;
#(
   parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                     clk,
   input  logic                     i_Rst_n,
   input  logic                     i_Valid0,
   input  logic                     i_Valid1,
   input  logic [8*BLOCK_BYTES-1:0] i_Block0,
   input  logic [8*BLOCK_BYTES-1:0] i_Block1,
   output logic                     o_Ready0,
   output logic                     o_Ready1,
   output logic                     o_Tx_DV,
   output logic [7:0]               o_Tx_Byte,
   input  logic                     i_Tx_Active,
   input  logic                     i_Tx_Done,
   output logic                     o_Busy,
   output logic                     o_Grant,
   output logic                     o_Blk_Done
);

   localparam int BLK_W = 8 * BLOCK_BYTES;
   localparam int CNT_W = cnt_width(BLOCK_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

   sched_state_t     state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [BLK_W-1:0] shift_reg;
   logic [BLK_W-1:0] shift_adv;
   logic [BLK_W-1:0] sel_block;
   logic             grant_reg;
   logic             last_grant_reg;
   logic             any_req;
   logic             winner;
   logic             busy;
   logic             tx_dv;
   logic             blk_done;
   logic [1:0]       ready_vec;

   rr_arbiter2 u_arb (
      .req0       (i_Valid0),
      .req1       (i_Valid1),
      .last_grant (last_grant_reg),
      .any_req    (any_req),
      .winner     (winner)
   );

   assign sel_block = grant_reg ? i_Block1 : i_Block0;

   // The outgoing byte always sits at the leading end of the shift register.
   generate
      if (MSB_FIRST) begin : g_msb
         assign o_Tx_Byte = shift_reg[BLK_W-1 -: 8];
         assign shift_adv = shift_reg << 8;
      end else begin : g_lsb
         assign o_Tx_Byte = shift_reg[7:0];
         assign shift_adv = shift_reg >> 8;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         assign ready_vec[gi] = (state_reg == LOAD) && (grant_reg == 1'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      tx_dv      = 1'b0;
      blk_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (any_req) state_next = LOAD;
         end
         LOAD: state_next = SYNC;
         // Never start while a frame (possibly from an abandoned block) is still on the wire.
         SYNC: if (!i_Tx_Active && !i_Tx_Done) state_next = SEND;
         SEND: begin
            tx_dv      = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (i_Tx_Done) state_next = (cnt_reg == LAST_IDX) ? FIN : GAP;
         end
         GAP:  state_next = SEND;
         FIN: begin
            blk_done   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_Rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         shift_reg      <= '0;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (any_req) grant_reg <= winner;
            LOAD: begin
               shift_reg <= sel_block;
               cnt_reg   <= '0;
            end
            WAIT: begin
               if (i_Tx_Done && (cnt_reg != LAST_IDX)) begin
                  cnt_reg   <= cnt_reg + 1'b1;
                  shift_reg <= shift_adv;
               end
            end
            FIN: last_grant_reg <= grant_reg;
            default: ;
         endcase
      end
   end

   assign o_Ready0   = ready_vec[0];
   assign o_Ready1   = ready_vec[1];
   assign o_Tx_DV    = tx_dv;
   assign o_Busy     = busy;
   assign o_Grant    = grant_reg;
   assign o_Blk_Done = blk_done;

endmodule

// File: tb/tb_uart_block_scheduler.sv
// Directed bench for uart_block_scheduler: MSB and LSB instances share one
// behavioural transmitter (bit period 4) and one set of requester inputs.
module tb_uart_block_scheduler;

   localparam int NB    = 8;
   localparam int FRAME = 10 * 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n   = 1'b0;
   logic        valid0  = 1'b0;
   logic        valid1  = 1'b0;
   logic [63:0] block0  = '0;
   logic [63:0] block1  = '0;
   logic        tx_active  = 1'b0;
   logic        model_done = 1'b0;
   logic        spur_done  = 1'b0;
   logic        tx_done_in;

   logic       ready0, ready1, tx_dv, busy, grant, blk_done;
   logic [7:0] tx_byte;
   logic       l_ready0, l_ready1, l_tx_dv, l_busy, l_grant, l_blk_done;
   logic [7:0] lsb_byte;

   assign tx_done_in = model_done | spur_done;

   uart_block_scheduler #(.BLOCK_BYTES(NB), .MSB_FIRST(1'b1)) u_dut (
      .clk(clk), .i_Rst_n(rst_n),
      .i_Valid0(valid0), .i_Valid1(valid1),
      .i_Block0(block0), .i_Block1(block1),
      .o_Ready0(ready0), .o_Ready1(ready1),
      .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
      .i_Tx_Active(tx_active), .i_Tx_Done(tx_done_in),
      .o_Busy(busy), .o_Grant(grant), .o_Blk_Done(blk_done)
   );

   uart_block_scheduler #(.BLOCK_BYTES(NB), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .i_Rst_n(rst_n),
      .i_Valid0(valid0), .i_Valid1(valid1),
      .i_Block0(block0), .i_Block1(block1),
      .o_Ready0(l_ready0), .o_Ready1(l_ready1),
      .o_Tx_DV(l_tx_dv), .o_Tx_Byte(lsb_byte),
      .i_Tx_Active(tx_active), .i_Tx_Done(tx_done_in),
      .o_Busy(l_busy), .o_Grant(l_grant), .o_Blk_Done(l_blk_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: accepts DV only when idle, frame lasts FRAME cycles,
   // Done pulses on the first idle cycle.
   int frame_cnt = 0;
   int frames    = 0;
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (tx_active) begin
         if (frame_cnt == FRAME - 1) begin
            tx_active  <= 1'b0;
            model_done <= 1'b1;
         end else begin
            frame_cnt <= frame_cnt + 1;
         end
      end else if (tx_dv) begin
         tx_active <= 1'b1;
         frame_cnt <= 0;
         frames    <= frames + 1;
      end
   end

   // Event recorder, sampled mid-cycle.
   logic [7:0] ev_dv_byte[$];
   logic [7:0] ev_dv_lsb[$];
   int         ev_dv_cyc[$];
   int         ev_done_cyc[$];
   int         ev_fall_cyc[$];
   int   r0_cnt = 0, r1_cnt = 0, bd_cnt = 0, bd_cyc = 0, ready_cyc = 0;
   int   dv_act_err = 0, dv_consec_err = 0, lsb_err = 0;
   logic grant_at_ready = 1'b0;
   logic prev_dv = 1'b0, prev_active = 1'b0;

   always @(negedge clk) begin
      if (tx_dv) begin
         ev_dv_byte.push_back(tx_byte);
         ev_dv_lsb.push_back(lsb_byte);
         ev_dv_cyc.push_back(cyc);
         if (tx_active) dv_act_err++;
         if (prev_dv) dv_consec_err++;
      end
      if (tx_done_in) ev_done_cyc.push_back(cyc);
      if (prev_active && !tx_active) ev_fall_cyc.push_back(cyc);
      if (ready0) r0_cnt++;
      if (ready1) r1_cnt++;
      if (ready0 || ready1) begin
         grant_at_ready = grant;
         ready_cyc      = cyc;
      end
      if (blk_done) begin
         bd_cnt++;
         bd_cyc = cyc;
      end
      if ({l_ready0, l_ready1, l_tx_dv, l_busy, l_grant, l_blk_done} !==
          {ready0, ready1, tx_dv, busy, grant, blk_done}) lsb_err++;
      prev_dv     = tx_dv;
      prev_active = tx_active;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int last_done_before(input int c);
      int r = -1000;
      foreach (ev_done_cyc[j]) if (ev_done_cyc[j] < c) r = ev_done_cyc[j];
      return r;
   endfunction

   // Runs one block to completion (inputs already applied) and checks it.
   task automatic run_txn(input string tag, input logic exp_grant, input logic [63:0] exp_blk,
                          input bit check_start, input bit drop_after_ready);
      int s_cyc, dv0, r0s, r1s, bds, fr0, act0, con0, le0, k, n_dv, c;
      bit dropped;
      s_cyc = cyc;
      dv0 = ev_dv_byte.size();
      r0s = r0_cnt; r1s = r1_cnt; bds = bd_cnt; fr0 = frames;
      act0 = dv_act_err; con0 = dv_consec_err; le0 = lsb_err;
      k = 0;
      dropped = 1'b0;
      while (bd_cnt == bds && k < 3000) begin
         @(posedge clk); #2;
         k++;
         if (drop_after_ready && !dropped && (r0_cnt + r1_cnt) != (r0s + r1s)) begin
            valid0  = 1'b0;
            valid1  = 1'b0;
            dropped = 1'b1;
         end
      end
      check({tag, "_no_timeout"}, 64'(k < 3000), 64'd1);
      check({tag, "_grant"}, 64'(grant_at_ready), 64'(exp_grant));
      check({tag, "_ready0_pulses"}, 64'(r0_cnt - r0s), 64'(exp_grant == 1'b0));
      check({tag, "_ready1_pulses"}, 64'(r1_cnt - r1s), 64'(exp_grant == 1'b1));
      check({tag, "_ready_latency"}, 64'(ready_cyc - s_cyc), 64'd1);
      n_dv = ev_dv_byte.size() - dv0;
      check({tag, "_dv_count"}, 64'(n_dv), 64'(NB));
      check({tag, "_frames"}, 64'(frames - fr0), 64'(NB));
      for (int i = 0; i < NB; i++) begin
         if (dv0 + i < ev_dv_byte.size()) begin
            check($sformatf("%s_msb_byte%0d", tag, i), 64'(ev_dv_byte[dv0 + i]),
                  64'(exp_blk[8*(NB-i)-1 -: 8]));
            check($sformatf("%s_lsb_byte%0d", tag, i), 64'(ev_dv_lsb[dv0 + i]),
                  64'(exp_blk[8*i+7 -: 8]));
            if (i > 0) begin
               c = ev_dv_cyc[dv0 + i];
               check($sformatf("%s_gap%0d", tag, i), 64'(c - last_done_before(c)), 64'd2);
            end
         end
      end
      if (check_start && n_dv > 0)
         check({tag, "_first_dv_latency"}, 64'(ev_dv_cyc[dv0] - s_cyc), 64'd3);
      check({tag, "_blk_done_delay"}, 64'(bd_cyc - last_done_before(bd_cyc)), 64'd1);
      check({tag, "_dv_while_active"}, 64'(dv_act_err - act0), 64'd0);
      check({tag, "_dv_back_to_back"}, 64'(dv_consec_err - con0), 64'd0);
      check({tag, "_lsb_instance_sync"}, 64'(lsb_err - le0), 64'd0);
      $display("txn %s: grant=%0d bytes=%0d done_cycle=%0d", tag, grant_at_ready, n_dv, bd_cyc);
   endtask

   typedef struct {
      logic        v0;
      logic        v1;
      logic [63:0] b0;
      logic [63:0] b1;
      logic        exp_grant;
      logic [63:0] exp_blk;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int dv0, fall0, k, bds, dvs;
      logic [63:0] blk_x, blk_y;

      // Tie from reset alternates 0,1,0,1; then single requests each side.
      vecs[0] = '{1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1122334455667788, 1'b0, 64'h0123456789ABCDEF};
      vecs[1] = '{1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1122334455667788, 1'b1, 64'h1122334455667788};
      vecs[2] = '{1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1122334455667788, 1'b0, 64'h0123456789ABCDEF};
      vecs[3] = '{1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1122334455667788, 1'b1, 64'h1122334455667788};
      vecs[4] = '{1'b0, 1'b1, 64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 1'b1, 64'hDEADBEEFCAFEF00D};
      vecs[5] = '{1'b1, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0, 64'h0123456789ABCDEF};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {56'd0, ready0, ready1, tx_dv, busy, grant, blk_done, 2'b00}, 64'd0);
      check("reset_tx_byte", 64'(tx_byte), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      for (int t = 0; t < 6; t++) begin
         valid0 = vecs[t].v0;
         valid1 = vecs[t].v1;
         block0 = vecs[t].b0;
         block1 = vecs[t].b1;
         run_txn($sformatf("vec%0d", t), vecs[t].exp_grant, vecs[t].exp_blk, 1'b1, 1'b0);
      end
      valid0 = 1'b0;
      valid1 = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      // Reset mid-block, one cycle after byte 3's DV.
      blk_x  = 64'h0011223344556677;
      blk_y  = 64'h8899AABBCCDDEEFF;
      block0 = blk_x;
      valid0 = 1'b1;
      dv0 = ev_dv_byte.size();
      k = 0;
      while (ev_dv_byte.size() < dv0 + 4 && k < 3000) begin
         @(posedge clk); #2;
         k++;
      end
      check("rst_reach_byte3", 64'(k < 3000), 64'd1);
      rst_n  = 1'b0;
      valid0 = 1'b0;
      @(posedge clk); #2;
      check("rst_mid_outputs", {58'd0, ready0, ready1, tx_dv, busy, grant, blk_done}, 64'd0);
      check("rst_mid_tx_byte", 64'(tx_byte), 64'd0);
      fall0 = ev_fall_cyc.size();
      dvs   = ev_dv_byte.size();
      rst_n  = 1'b1;
      block0 = blk_y;
      block1 = blk_x;
      valid0 = 1'b1;
      valid1 = 1'b1;
      run_txn("after_rst", 1'b0, blk_y, 1'b0, 1'b1);
      if (ev_fall_cyc.size() > fall0 && ev_dv_byte.size() > dvs)
         check("after_rst_waits_for_idle", 64'(ev_dv_cyc[dvs] - ev_fall_cyc[fall0]), 64'd2);
      else
         check("after_rst_events_seen", 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #2;

      // Spurious Done while idle.
      bds = bd_cnt;
      dvs = ev_dv_byte.size();
      spur_done = 1'b1;
      @(posedge clk); #2;
      spur_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("spurious_busy%0d", i), 64'(busy), 64'd0);
         @(posedge clk); #2;
      end
      check("spurious_blk_done", 64'(bd_cnt - bds), 64'd0);
      check("spurious_dv", 64'(ev_dv_byte.size() - dvs), 64'd0);
      $display("txn spurious_done: busy=%0d blk_done_pulses=%0d", busy, bd_cnt - bds);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
